// File: rtl/multi_blinker_pkg.sv
// Shared types and default sizing for the multi-channel blinker.
// Mode and burst-state encodings are common to the top level and every channel.
package multi_blinker_pkg;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_SHIFT_W   = 4;
    localparam int DEF_BURST_W   = 4;
    localparam int DEF_RST_SHIFT = 7;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        BST_IDLE   = 2'd0,
        BST_ACTIVE = 2'd1,
        BST_DONE   = 2'd2
    } burst_state_e;

endpackage

// File: rtl/multi_blinker_channel.sv
// One blink channel: live config registers, tap/period-boundary logic, burst FSM, output flop.
// Optional per-channel output inversion is built when MULTI_BLINKER_POLARITY_EN is defined.
module blink_channel
    import multi_blinker_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int RST_SHIFT = DEF_RST_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   count,
    input  logic               apply_req,
    input  mode_e              cfg_mode,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [CNT_W-1:0]   cfg_phase,
    input  logic [BURST_W-1:0] cfg_burst,
`ifdef MULTI_BLINKER_POLARITY_EN
    input  logic               cfg_invert,
`endif
    output logic               apply_ok,
    output logic               blink_out,
    output logic               burst_done
);

    mode_e              mode_q, mode_d;
    burst_state_e       state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               tap_prev_q, tap_prev_d;
    logic               out_q, out_d;
    logic               done_q, done_d;
    logic               invert_q, invert_d;

    logic [CNT_W-1:0]   pc;
    logic [SHIFT_W-1:0] eff_shift;
    logic [CNT_W:0]     period_mask;
    logic               tap;
    logic               do_apply;
    logic               raw;

    always_comb begin
        pc = count + phase_q;
        if ({{(32-SHIFT_W){1'b0}}, shift_q} >= 32'(CNT_W)) begin
            eff_shift = SHIFT_W'(CNT_W - 1);
        end else begin
            eff_shift = shift_q;
        end
        tap = pc[eff_shift];
        // One extra bit so the mask for the top tap (all ones) cannot overflow.
        period_mask = ((CNT_W+1)'(2) << eff_shift) - (CNT_W+1)'(1);
        apply_ok = (mode_q == MODE_OFF) || ((pc & period_mask[CNT_W-1:0]) == '0);
        do_apply = apply_req && apply_ok;
    end

    always_comb begin
        mode_d     = mode_q;
        state_d    = state_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        rem_d      = rem_q;
        invert_d   = invert_q;
        tap_prev_d = tap;
        done_d     = 1'b0;

        if (do_apply) begin
            mode_d     = cfg_mode;
            shift_d    = cfg_shift;
            phase_d    = cfg_phase;
            rem_d      = cfg_burst;
`ifdef MULTI_BLINKER_POLARITY_EN
            invert_d   = cfg_invert;
`endif
            // The new tap may differ from the old one; never count that as a falling edge.
            tap_prev_d = 1'b0;
            if (cfg_mode == MODE_BURST) begin
                state_d = (cfg_burst == '0) ? BST_DONE : BST_ACTIVE;
            end else begin
                state_d = BST_IDLE;
            end
        end else if (state_q == BST_ACTIVE && tap_prev_q && !tap) begin
            if (rem_q == BURST_W'(1)) begin
                rem_d   = '0;
                state_d = BST_DONE;
                done_d  = 1'b1;
            end else begin
                rem_d = rem_q - BURST_W'(1);
            end
        end

        case (mode_q)
            MODE_OFF:   raw = 1'b0;
            MODE_ON:    raw = 1'b1;
            MODE_BLINK: raw = tap;
            default:    raw = (state_q == BST_ACTIVE) ? tap : 1'b0;
        endcase
        out_d = raw ^ invert_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_OFF;
            state_q    <= BST_IDLE;
            shift_q    <= SHIFT_W'(RST_SHIFT);
            phase_q    <= '0;
            rem_q      <= '0;
            tap_prev_q <= 1'b0;
            out_q      <= 1'b0;
            done_q     <= 1'b0;
            invert_q   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            rem_q      <= rem_d;
            tap_prev_q <= tap_prev_d;
            out_q      <= out_d;
            done_q     <= done_d;
            invert_q   <= invert_d;
        end
    end

    assign blink_out  = out_q;
    assign burst_done = done_q;

endmodule

// File: rtl/multi_blinker.sv
// Top of the multi-channel blinker: shared counter, single-entry config slot and channel decode.
// Defining MULTI_BLINKER_POLARITY_EN adds the cfg_invert input and per-channel output inversion.
module multi_blinker
    import multi_blinker_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int RST_SHIFT = DEF_RST_SHIFT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic [CNT_W-1:0]    cfg_phase,
    input  logic [BURST_W-1:0]  cfg_burst,
`ifdef MULTI_BLINKER_POLARITY_EN
    input  logic                cfg_invert,
`endif
    output logic [CNT_W-1:0]    count,
    output logic [CHANNELS-1:0] blink_out,
    output logic [CHANNELS-1:0] burst_done
);

    logic [CNT_W-1:0]   count_q, count_d;
    logic               pend_vld_q, pend_vld_d;
    logic [2:0]         pend_ch_q, pend_ch_d;
    mode_e              pend_mode_q, pend_mode_d;
    logic [SHIFT_W-1:0] pend_shift_q, pend_shift_d;
    logic [CNT_W-1:0]   pend_phase_q, pend_phase_d;
    logic [BURST_W-1:0] pend_burst_q, pend_burst_d;
    logic               pend_inv_q, pend_inv_d;

    logic [CHANNELS-1:0] apply_req;
    logic [CHANNELS-1:0] apply_ok;
    logic                accept;
    logic                applied;

    always_comb begin
        count_d      = ena ? count_q + CNT_W'(1) : count_q;
        pend_vld_d   = pend_vld_q;
        pend_ch_d    = pend_ch_q;
        pend_mode_d  = pend_mode_q;
        pend_shift_d = pend_shift_q;
        pend_phase_d = pend_phase_q;
        pend_burst_d = pend_burst_q;
        pend_inv_d   = pend_inv_q;

        accept  = cfg_valid && !pend_vld_q;
        applied = |(apply_req & apply_ok);

        if (accept) begin
            // Writes to channels that do not exist are acknowledged but never occupy the slot.
            pend_vld_d   = ({29'd0, cfg_ch} < 32'(CHANNELS));
            pend_ch_d    = cfg_ch;
            pend_mode_d  = mode_e'(cfg_mode);
            pend_shift_d = cfg_shift;
            pend_phase_d = cfg_phase;
            pend_burst_d = cfg_burst;
`ifdef MULTI_BLINKER_POLARITY_EN
            pend_inv_d   = cfg_invert;
`endif
        end else if (applied) begin
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            pend_vld_q   <= 1'b0;
            pend_ch_q    <= '0;
            pend_mode_q  <= MODE_OFF;
            pend_shift_q <= '0;
            pend_phase_q <= '0;
            pend_burst_q <= '0;
            pend_inv_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            pend_vld_q   <= pend_vld_d;
            pend_ch_q    <= pend_ch_d;
            pend_mode_q  <= pend_mode_d;
            pend_shift_q <= pend_shift_d;
            pend_phase_q <= pend_phase_d;
            pend_burst_q <= pend_burst_d;
            pend_inv_q   <= pend_inv_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign apply_req[i] = pend_vld_q && (pend_ch_q == 3'(i));

        blink_channel #(
            .CNT_W     (CNT_W),
            .SHIFT_W   (SHIFT_W),
            .BURST_W   (BURST_W),
            .RST_SHIFT (RST_SHIFT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .count      (count_q),
            .apply_req  (apply_req[i]),
            .cfg_mode   (pend_mode_q),
            .cfg_shift  (pend_shift_q),
            .cfg_phase  (pend_phase_q),
            .cfg_burst  (pend_burst_q),
`ifdef MULTI_BLINKER_POLARITY_EN
            .cfg_invert (pend_inv_q),
`endif
            .apply_ok   (apply_ok[i]),
            .blink_out  (blink_out[i]),
            .burst_done (burst_done[i])
        );
    end

    assign cfg_ready = !pend_vld_q;
    assign count     = count_q;

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker: vector table for reset/counter, hand sequences for config,
// period-boundary apply, phase lead, bursts, invalid channel and reset with a pending write.
module tb_multi_blinker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_shift;
    logic [15:0] cfg_phase;
    logic [3:0]  cfg_burst;
`ifdef MULTI_BLINKER_POLARITY_EN
    logic        cfg_invert = 1'b0;
`endif
    logic [15:0] count;
    logic [3:0]  blink_out;
    logic [3:0]  burst_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] tb_cnt;

    multi_blinker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_shift  (cfg_shift),
        .cfg_phase  (cfg_phase),
        .cfg_burst  (cfg_burst),
`ifdef MULTI_BLINKER_POLARITY_EN
        .cfg_invert (cfg_invert),
`endif
        .count      (count),
        .blink_out  (blink_out),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (tb_cnt=%0d)", name, act, exp, tb_cnt);
        end
    endtask

    // Advance one clock; outputs are sampled on the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (ena) tb_cnt = tb_cnt + 16'd1;
        @(negedge clk);
    endtask

    // Waits (bounded) for cfg_ready, then presents one write for exactly one accepting edge.
    task automatic send(input logic [2:0] ch, input logic [1:0] mode, input logic [3:0] shift,
                        input logic [15:0] phase, input logic [3:0] burst);
        int n;
        n = 0;
        cfg_ch = ch; cfg_mode = mode; cfg_shift = shift; cfg_phase = phase; cfg_burst = burst;
        while (!cfg_ready && n < 64) begin
            tick();
            n++;
        end
        if (n == 64) chk("send_ready_timeout", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic        ena;
        logic [15:0] exp_cnt;
        logic [3:0]  exp_blink;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] pre;
        logic [15:0] lead;
        logic        committed;
        logic        prev;
        int hi, rises, dn, dn_at;

        vecs[0] = '{1'b1, 16'd1, 4'h0, 1'b1};
        vecs[1] = '{1'b1, 16'd2, 4'h0, 1'b1};
        vecs[2] = '{1'b1, 16'd3, 4'h0, 1'b1};
        vecs[3] = '{1'b0, 16'd3, 4'h0, 1'b1};
        vecs[4] = '{1'b0, 16'd3, 4'h0, 1'b1};
        vecs[5] = '{1'b1, 16'd4, 4'h0, 1'b1};
        vecs[6] = '{1'b1, 16'd5, 4'h0, 1'b1};
        vecs[7] = '{1'b1, 16'd6, 4'h0, 1'b1};

        rst_n = 1'b0; ena = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_shift = '0; cfg_phase = '0; cfg_burst = '0;
        tb_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_blink", 32'(blink_out), 32'd0);
        chk("rst_done", 32'(burst_done), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;

        // Counter with enable, no configuration.
        for (int i = 0; i < 8; i++) begin
            ena = vecs[i].ena;
            tick();
            chk("vec_count", 32'(count), 32'(vecs[i].exp_cnt));
            chk("vec_blink", 32'(blink_out), 32'(vecs[i].exp_blink));
            chk("vec_ready", 32'(cfg_ready), 32'(vecs[i].exp_ready));
        end
        ena = 1'b1;

        // ch0 BLINK shift 0: OFF channel applies on the edge after acceptance.
        send(3'd0, 2'd2, 4'd0, 16'd0, 4'd0);
        chk("A_ready_low", 32'(cfg_ready), 32'd0);
        tick();
        chk("A_ready_back", 32'(cfg_ready), 32'd1);
        chk("A_apply_edge_out", 32'(blink_out[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            pre = tb_cnt - 16'd1;
            chk("A_blink0", 32'(blink_out[0]), 32'(pre[0]));
        end

        // ch1 BLINK shift 3, then rewrite to shift 1 at count 5; commit waits for pc mod 16 == 0.
        send(3'd1, 2'd2, 4'd3, 16'd0, 4'd0);
        tick();
        for (int i = 0; i < 20 && tb_cnt[3:0] != 4'd5; i++) tick();
        chk("B_at_5", 32'(count[3:0]), 32'd5);
        send(3'd1, 2'd2, 4'd1, 16'd0, 4'd0);
        chk("B_ready_low", 32'(cfg_ready), 32'd0);
        committed = 1'b0;
        for (int i = 0; i < 20 && !committed; i++) begin
            pre = tb_cnt;
            tick();
            committed = (pre[3:0] == 4'd0);
            chk("B_ready", 32'(cfg_ready), 32'(committed));
            chk("B_old_period", 32'(blink_out[1]), 32'(pre[3]));
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            pre = tb_cnt - 16'd1;
            chk("B_new_period", 32'(blink_out[1]), 32'(pre[1]));
        end

        // ch2 phase 0 vs ch3 phase 2, both shift 2.
        send(3'd2, 2'd2, 4'd2, 16'd0, 4'd0);
        send(3'd3, 2'd2, 4'd2, 16'd2, 4'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            pre  = tb_cnt - 16'd1;
            lead = pre + 16'd2;
            chk("C_ch2", 32'(blink_out[2]), 32'(pre[2]));
            chk("C_ch3", 32'(blink_out[3]), 32'(lead[2]));
        end
        chk("C_count", 32'(count), 32'(tb_cnt));

        // ch0 OFF, then BURST shift 1 length 3 timed so the new tap starts low.
        send(3'd0, 2'd0, 4'd0, 16'd0, 4'd0);
        for (int i = 0; i < 8 && !cfg_ready; i++) tick();
        for (int i = 0; i < 8 && tb_cnt[1:0] != 2'd2; i++) tick();
        send(3'd0, 2'd3, 4'd1, 16'd0, 4'd3);
        tick();
        chk("D_apply_ready", 32'(cfg_ready), 32'd1);
        hi = 0; rises = 0; dn = 0; dn_at = -1; prev = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (blink_out[0]) hi++;
            if (blink_out[0] && !prev) rises++;
            prev = blink_out[0];
            if (burst_done[0]) begin
                dn++;
                dn_at = k;
            end
        end
        chk("D_high_cycles", 32'(hi), 32'd6);
        chk("D_pulses", 32'(rises), 32'd3);
        chk("D_done_count", 32'(dn), 32'd1);
        chk("D_done_time", 32'(dn_at), 32'd13);
        chk("D_hold_low", 32'(blink_out[0]), 32'd0);

        // BURST length 0 from DONE: straight to DONE, output low, no pulse.
        send(3'd0, 2'd3, 4'd1, 16'd0, 4'd0);
        dn = 0; hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (burst_done[0]) dn++;
            if (blink_out[0]) hi++;
        end
        chk("D0_ready", 32'(cfg_ready), 32'd1);
        chk("D0_no_pulse", 32'(dn), 32'd0);
        chk("D0_low", 32'(hi), 32'd0);

        // Write to a non-existent channel.
        send(3'd7, 2'd1, 4'd0, 16'd0, 4'd0);
        chk("E_bad_ch_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("E_bad_ch_ready2", 32'(cfg_ready), 32'd1);
        chk("E_ch0_unchanged", 32'(blink_out[0]), 32'd0);

        // Reset while a write to ch1 is still waiting for its boundary.
        for (int i = 0; i < 8 && tb_cnt[1:0] != 2'd1; i++) tick();
        send(3'd1, 2'd1, 4'd0, 16'd0, 4'd0);
        chk("E_pending", 32'(cfg_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("R_count", 32'(count), 32'd0);
        chk("R_blink", 32'(blink_out), 32'd0);
        chk("R_done", 32'(burst_done), 32'd0);
        chk("R_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tb_cnt = '0;
        repeat (4) tick();
        chk("R_after_count", 32'(count), 32'd4);
        chk("R_after_blink", 32'(blink_out), 32'd0);
        chk("R_after_ready", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
